// File: rtl/dmem_responder.sv
// dmem_responder: single-port word-organised data memory answering the core's
// load/store request handshake with a fixed, parameterised response latency.
// Optional feature: define DMEM_RANGE_CHECK_EN to add a sticky err_o flag that
// fires on addresses beyond the array depth and suppresses their access.
module dmem_responder #(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic        valid_i,
  input  logic        wen_i,
  input  logic        byte_not_word_i,
  input  logic        yumi_i,
  output logic [31:0] read_data_o,
  output logic        valid_o,
  output logic        yumi_o
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic        err_o
`endif
);

  localparam int depth_lp = 1 << addr_width_p;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [depth_lp];

  logic [addr_width_p-1:0] word_idx;
  logic [1:0]              lane;
  logic [31:0]             upper_bits;
  logic                    addr_ok;
  logic [31:0]             rd_word;
  logic [31:0]             rd_byte;
  logic                    mem_we;
  logic [3:0]              byte_en;
  logic [31:0]             wr_word;

  assign word_idx   = addr_i[2 +: addr_width_p];
  assign lane       = addr_i[1:0];
  assign upper_bits = addr_i >> (addr_width_p + 2);

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q, err_d;
  assign addr_ok = (upper_bits == 32'd0);
  assign err_o   = err_q;
`else
  logic unused_upper_bits;
  assign unused_upper_bits = ^upper_bits;
  assign addr_ok = 1'b1;
`endif

  assign read_data_o = rdata_q;
  assign valid_o     = valid_q;

  // Accept strobe, storage read path and store write-enable / lane merge
  always_comb begin
    yumi_o  = (state_q == IDLE) && valid_i;
    rd_word = mem_q[word_idx];
    case (lane)
      2'd0:    rd_byte = {24'h0, rd_word[7:0]};
      2'd1:    rd_byte = {24'h0, rd_word[15:8]};
      2'd2:    rd_byte = {24'h0, rd_word[23:16]};
      default: rd_byte = {24'h0, rd_word[31:24]};
    endcase
    mem_we  = yumi_o && reset && wen_i && addr_ok;
    byte_en = byte_not_word_i ? (4'b0001 << lane) : 4'b1111;
    wr_word = byte_not_word_i ? {4{write_data_i[7:0]}} : write_data_i;
  end

  // Next-state logic for the handshake FSM, latency counter and response data
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (!wen_i && addr_ok) rdata_d = byte_not_word_i ? rd_byte : rd_word;
          else                   rdata_d = 32'h0;
          cnt_d   = 4'(latency_p - 1);
          state_d = (latency_p == 1) ? RESP : WAIT;
`ifdef DMEM_RANGE_CHECK_EN
          if (!addr_ok) err_d = 1'b1;
`endif
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == RESP);
  end

  // FSM and registered response outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
`ifdef DMEM_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
`ifdef DMEM_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Storage array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && byte_en[i]) mem_q[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (latency 1 and latency 3) driven
// with identical requests and compared against a byte-addressed memory model.
// Honours DMEM_RANGE_CHECK_EN when the design is built with it.
module tb_dmem_responder;

  localparam int AW = 10;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic        valid_i;
  logic        wen_i;
  logic        byte_not_word_i;
  logic        yumi_i;

  logic [31:0] rdata1, rdata3;
  logic        valid1, valid3;
  logic        yumi1, yumi3;
`ifdef DMEM_RANGE_CHECK_EN
  logic        err1, err3;
  logic        errModel;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] memModel [4096];

  dmem_responder #(.addr_width_p(AW), .latency_p(1)) u_dut1 (
    .clk(clk), .reset(reset), .addr_i(addr_i), .write_data_i(write_data_i),
    .valid_i(valid_i), .wen_i(wen_i), .byte_not_word_i(byte_not_word_i),
    .yumi_i(yumi_i), .read_data_o(rdata1), .valid_o(valid1), .yumi_o(yumi1)
`ifdef DMEM_RANGE_CHECK_EN
    , .err_o(err1)
`endif
  );

  dmem_responder #(.addr_width_p(AW), .latency_p(3)) u_dut3 (
    .clk(clk), .reset(reset), .addr_i(addr_i), .write_data_i(write_data_i),
    .valid_i(valid_i), .wen_i(wen_i), .byte_not_word_i(byte_not_word_i),
    .yumi_i(yumi_i), .read_data_o(rdata3), .valid_o(valid3), .yumi_o(yumi3)
`ifdef DMEM_RANGE_CHECK_EN
    , .err_o(err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkErr();
`ifdef DMEM_RANGE_CHECK_EN
    checkOutput("err_l1", err1, errModel);
    checkOutput("err_l3", err3, errModel);
`endif
  endtask

  // Behavioural model: memory is a flat byte array, little-endian lanes
  task automatic modelAccess(input logic [31:0] a, input logic [31:0] wd, input logic we,
                             input logic bw, output logic [31:0] rd);
    int  base;
    bit  oor;
    base = int'(a[11:2]) * 4;
    oor  = RC && (a[31:12] != 20'h0);
    rd   = 32'h0;
`ifdef DMEM_RANGE_CHECK_EN
    if (oor) errModel = 1'b1;
`endif
    if (!oor) begin
      if (we) begin
        if (bw) memModel[a[11:0]] = wd[7:0];
        else for (int i = 0; i < 4; i++) memModel[base + i] = wd[8*i +: 8];
      end else begin
        if (bw) rd = {24'h0, memModel[a[11:0]]};
        else    rd = {memModel[base + 3], memModel[base + 2], memModel[base + 1], memModel[base]};
      end
    end
  endtask

  // One full transaction; entered and left just after a rising edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic we,
                               input logic bw, input int stall);
    logic [31:0] expData;
    int last;
    last = 3 + stall;
    addr_i = a; write_data_i = wd; wen_i = we; byte_not_word_i = bw;
    valid_i = 1'b1; yumi_i = 1'b0;
    @(negedge clk);
    checkOutput("accept_yumi_l1", yumi1, 1);
    checkOutput("accept_yumi_l3", yumi3, 1);
    checkOutput("idle_valid_l1", valid1, 0);
    checkOutput("idle_valid_l3", valid3, 0);
    checkErr();
    modelAccess(a, wd, we, bw, expData);
    @(posedge clk); #1;
    for (int k = 1; k <= last; k++) begin
      valid_i = 1'b1;
      addr_i = $urandom; write_data_i = $urandom;
      wen_i = 1'($urandom_range(0, 1)); byte_not_word_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("resp_valid_l1", valid1, 1);
      checkOutput("resp_data_l1", rdata1, expData);
      checkOutput("resp_valid_l3", valid3, (k >= 3) ? 32'd1 : 32'd0);
      if (k >= 3) checkOutput("resp_data_l3", rdata3, expData);
      checkOutput("busy_yumi_l1", yumi1, 0);
      checkOutput("busy_yumi_l3", yumi3, 0);
      checkErr();
      if (k == last) begin
        yumi_i = 1'b1;
        valid_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    yumi_i = 1'b0;
    @(negedge clk);
    checkOutput("drop_valid_l1", valid1, 0);
    checkOutput("drop_valid_l3", valid3, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] upper;
    logic [31:0] addr;
    reset = 1'b0; addr_i = 0; write_data_i = 0; valid_i = 0;
    wen_i = 0; byte_not_word_i = 0; yumi_i = 0;
`ifdef DMEM_RANGE_CHECK_EN
    errModel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_valid_l1", valid1, 0);
    checkOutput("rst_data_l1", rdata1, 0);
    checkOutput("rst_valid_l3", valid3, 0);
    checkOutput("rst_data_l3", rdata3, 0);
    checkErr();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_valid_l1", valid1, 0);
      checkOutput("idle_yumi_l1", yumi1, 0);
      checkOutput("idle_data_l1", rdata1, 0);
      checkOutput("idle_valid_l3", valid3, 0);
      checkOutput("idle_yumi_l3", yumi3, 0);
      checkOutput("idle_data_l3", rdata3, 0);
      checkErr();
      @(posedge clk); #1;
    end

    $display("[TB] preloading words 0..15");
    for (int i = 0; i < 16; i++) applyStimulus(32'(i) << 2, $urandom, 1'b1, 1'b0, 0);

    $display("[TB] directed word and byte accesses");
    applyStimulus(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 0);
    applyStimulus(32'h10, 32'h0, 1'b0, 1'b0, 0);
    applyStimulus(32'h20, 32'h11223344, 1'b1, 1'b0, 0);
    applyStimulus(32'h22, 32'h000000AA, 1'b1, 1'b1, 1);
    applyStimulus(32'h20, 32'h0, 1'b0, 1'b0, 0);
    applyStimulus(32'h23, 32'h0, 1'b0, 1'b1, 0);
    applyStimulus(32'h20, 32'h0, 1'b0, 1'b0, 5);

    $display("[TB] reset while a store response is pending");
    addr_i = 32'h40; write_data_i = 32'h55; wen_i = 1'b1; byte_not_word_i = 1'b0;
    valid_i = 1'b1;
    @(negedge clk);
    checkOutput("rstwait_yumi_l1", yumi1, 1);
    checkOutput("rstwait_yumi_l3", yumi3, 1);
    modelAccess(32'h40, 32'h55, 1'b1, 1'b0, addr);
    @(posedge clk); #1;
    valid_i = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstwait_pre_valid_l1", valid1, 1);
    checkOutput("rstwait_pre_valid_l3", valid3, 0);
    @(posedge clk); #1;
    reset = 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
    errModel = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rstwait_valid_l1", valid1, 0);
      checkOutput("rstwait_valid_l3", valid3, 0);
      @(posedge clk); #1;
    end
    applyStimulus(32'h40, 32'h0, 1'b0, 1'b0, 1);

`ifdef DMEM_RANGE_CHECK_EN
    $display("[TB] out-of-range store");
    applyStimulus(32'h0, 32'h0BADF00D, 1'b1, 1'b0, 0);
    applyStimulus(32'h00001000, 32'hCAFEF00D, 1'b1, 1'b0, 0);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 2);
    applyStimulus(32'h00001004, 32'h0, 1'b0, 1'b0, 0);
`endif

    $display("[TB] randomized accesses");
    for (int n = 0; n < 40; n++) begin
      if (RC) upper = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFF000) : 32'h0;
      else    upper = $urandom & 32'hFFFFF000;
      addr = upper | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(addr, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
